sc_eval_ctrl: RTL and testbench



---
 rtl/sc_pkg.sv | 27 ++
 rtl/sc_win_cnt.sv | 32 +++
 rtl/sc_eval_ctrl.sv | 143 ++++++++++++++
 tb/tb_sc_eval_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
//  sc_pkg
//  Shared types and helpers for the stochastic evaluation controller.
//  Revision: 1.0
// ============================================================================
package sc_pkg;

    typedef enum logic [2:0] {
        SC_IDLE  = 3'd0,
        SC_CLEAR = 3'd1,
        SC_FLUSH = 3'd2,
        SC_WARM  = 3'd3,
        SC_RUN   = 3'd4,
        SC_CAPT  = 3'd5,
        SC_DONE  = 3'd6
    } sc_state_t;

    // Substitute seed, an all-zero LFSR seed would lock up the SNG.
    localparam int unsigned SC_SEED0 = 32'h008;

    function automatic int unsigned sc_len(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_win_cnt.sv
`default_nettype none
// ============================================================================
//  sc_win_cnt
//  Loadable N-bit down-counter with terminal-count flag; stops at zero.
//  Revision: 1.0
// ============================================================================
module sc_win_cnt #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    output logic         o_tc
);

    logic [N-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - N'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sc_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  sc_eval_ctrl
//  Sequences one sng -> stanh -> dru evaluation: clear, flush, count a
//  2^N-1 cycle window, capture the DRU count. Optional macro SC_WARMUP_EN
//  inserts a WARMUP-cycle stanh settling stage before the counting window.
//  Revision: 1.0
// ============================================================================
module sc_eval_ctrl
    import sc_pkg::*;
#(
    parameter int             N      = 10,
    parameter int             PIPE   = 2,
    parameter int             WARMUP = 16,
    parameter logic [N-1:0]   SEED0  = N'(SC_SEED0)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_seed,
    input  logic         abort,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic [N-1:0] sng_a,
    output logic [N-1:0] sng_seed,
    output logic         dp_rst,
    output logic         dru_rst,
    input  logic [N-1:0] dru_cnt,
    output logic         busy
);

    localparam logic [N-1:0] C_FLUSH_LAST = N'(PIPE - 1);
    localparam logic [N-1:0] C_RUN_LAST   = N'(sc_len(N) - 32'd1);

    sc_state_t    r_state;
    sc_state_t    w_state_nxt;
    logic         w_tc;
    logic         w_load;
    logic [N-1:0] w_load_val;
    logic         w_in_eval;
    logic         w_accept;
    logic         w_capture;
    logic [N-1:0] r_sng_a;
    logic [N-1:0] r_sng_seed;
    logic         r_rsp_valid;
    logic [N-1:0] r_rsp_data;

`ifndef SC_WARMUP_EN
    logic [N-1:0] w_unused_warmup;
    assign w_unused_warmup = N'(WARMUP);
`endif

    assign w_in_eval = (r_state != SC_IDLE) && (r_state != SC_DONE);
    assign w_accept  = (r_state == SC_IDLE) && req_valid;
    assign w_capture = (r_state == SC_CAPT) && !abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SC_IDLE:  if (req_valid) w_state_nxt = SC_CLEAR;
            SC_CLEAR: w_state_nxt = SC_FLUSH;
`ifdef SC_WARMUP_EN
            SC_FLUSH: if (w_tc) w_state_nxt = SC_WARM;
            SC_WARM:  if (w_tc) w_state_nxt = SC_RUN;
`else
            SC_FLUSH: if (w_tc) w_state_nxt = SC_RUN;
`endif
            SC_RUN:   if (w_tc) w_state_nxt = SC_CAPT;
            SC_CAPT:  w_state_nxt = SC_DONE;
            SC_DONE:  if (rsp_ready) w_state_nxt = SC_IDLE;
            default:  w_state_nxt = SC_IDLE;
        endcase
        if (abort && w_in_eval) begin
            w_state_nxt = SC_IDLE;
        end
    end

    // Every state change reloads the window with the new stage's length - 1.
    always_comb begin
        w_load     = (w_state_nxt != r_state);
        w_load_val = '0;
        case (w_state_nxt)
            SC_FLUSH: w_load_val = C_FLUSH_LAST;
`ifdef SC_WARMUP_EN
            SC_WARM:  w_load_val = N'(WARMUP - 1);
`endif
            SC_RUN:   w_load_val = C_RUN_LAST;
            default:  w_load_val = '0;
        endcase
    end

    sc_win_cnt #(
        .N (N)
    ) u_win_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sng_a     <= '0;
            r_sng_seed  <= SEED0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_sng_a    <= req_a;
                r_sng_seed <= (req_seed == '0) ? SEED0 : req_seed;
            end
            if (w_capture) begin
                r_rsp_data  <= dru_cnt;
                r_rsp_valid <= 1'b1;
            end else if ((r_state == SC_DONE) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = (r_state == SC_IDLE);
    assign busy      = (r_state != SC_IDLE);
    assign dp_rst    = (r_state == SC_FLUSH) || (r_state == SC_WARM) || (r_state == SC_RUN);
    assign dru_rst   = (r_state == SC_RUN);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign sng_a     = r_sng_a;
    assign sng_seed  = r_sng_seed;

endmodule
`default_nettype wire

// File: tb/tb_sc_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_sc_eval_ctrl
//  Scoreboard bench: N=10 controller (main) plus an N=4 instance for the short case.
//  Revision: 1.0
// ============================================================================
module tb_sc_eval_ctrl;

`ifdef SC_WARMUP_EN
    localparam int WD = 16;
    localparam int WB = 4;
`else
    localparam int WD = 0;
    localparam int WB = 0;
`endif
    localparam int LAT_D = 1027 + WD;
    localparam int LAT_B = 19 + WB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       d_req_valid = 1'b0, d_abort = 1'b0, d_rsp_ready = 1'b1;
    logic       d_req_ready, d_rsp_valid, d_dp_rst, d_dru_rst, d_busy;
    logic [9:0] d_req_a = '0, d_req_seed = '0;
    logic [9:0] d_rsp_data, d_sng_a, d_sng_seed, d_dru_cnt;

    logic       b_req_valid = 1'b0;
    logic       b_req_ready, b_rsp_valid, b_dp_rst, b_dru_rst, b_busy;
    logic [3:0] b_req_a = '0, b_req_seed = '0;
    logic [3:0] b_rsp_data, b_sng_a, b_sng_seed, b_dru_cnt;

    sc_eval_ctrl #(.N(10), .PIPE(2), .WARMUP(16)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(d_req_valid), .req_ready(d_req_ready),
        .req_a(d_req_a), .req_seed(d_req_seed), .abort(d_abort),
        .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready), .rsp_data(d_rsp_data),
        .sng_a(d_sng_a), .sng_seed(d_sng_seed),
        .dp_rst(d_dp_rst), .dru_rst(d_dru_rst), .dru_cnt(d_dru_cnt), .busy(d_busy)
    );

    sc_eval_ctrl #(.N(4), .PIPE(2), .WARMUP(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_a(b_req_a), .req_seed(b_req_seed), .abort(1'b0),
        .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_data(b_rsp_data),
        .sng_a(b_sng_a), .sng_seed(b_sng_seed),
        .dp_rst(b_dp_rst), .dru_rst(b_dru_rst), .dru_cnt(b_dru_cnt), .busy(b_busy)
    );

    // Stand-in datapath: ramp^seed compared with A, two pipe stages, ones-counter.
    logic [9:0] d_ramp;
    logic       d_p1, d_p2;
    logic [3:0] b_ramp;
    logic       b_p1, b_p2;

    always @(posedge clk) begin
        if (!d_dp_rst) begin
            d_ramp <= '0; d_p1 <= 1'b0; d_p2 <= 1'b0;
        end else begin
            d_ramp <= d_ramp + 10'd1;
            d_p1   <= ((d_ramp ^ d_sng_seed) < d_sng_a);
            d_p2   <= d_p1;
        end
        d_dru_cnt <= d_dru_rst ? d_dru_cnt + {9'd0, d_p2} : 10'd0;
        if (!b_dp_rst) begin
            b_ramp <= '0; b_p1 <= 1'b0; b_p2 <= 1'b0;
        end else begin
            b_ramp <= b_ramp + 4'd1;
            b_p1   <= ((b_ramp ^ b_sng_seed) < b_sng_a);
            b_p2   <= b_p1;
        end
        b_dru_cnt <= b_dru_rst ? b_dru_cnt + {3'd0, b_p2} : 4'd0;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] data;
        int         e0;
    } exp_t;
    exp_t       sb[$];
    exp_t       e_push, e_pop;
    logic       mon_prev = 1'b0;
    logic [9:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Over 2^n-1 window cycles the ramp skips exactly one value: (w-1) mod 2^n.
    function automatic logic [31:0] exp_cnt(input int a, input int seed, input int n, input int w);
        int m, s, miss;
        m    = (1 << n) - 1;
        s    = (seed == 0) ? 8 : seed;
        miss = ((w - 1) & m) ^ s;
        return 32'((miss < a) ? a - 1 : a);
    endfunction

    always @(negedge clk) begin
        if (d_rsp_valid === 1'b1 && mon_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e_pop = sb.pop_front();
                check("rsp_data", 32'(d_rsp_data), 32'(e_pop.data));
                check("rsp_latency", 32'(cyc - e_pop.e0), 32'(LAT_D));
            end
        end
        mon_prev = d_rsp_valid;
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic [9:0] a, input logic [9:0] seed,
                        input bit expect_rsp, input logic [9:0] exp_data);
        d_req_a     = a;
        d_req_seed  = seed;
        d_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (d_req_ready === 1'b1) begin
                @(negedge clk);
                d_req_valid = 1'b0;
                if (expect_rsp) begin
                    e_push.data = exp_data;
                    e_push.e0   = cyc;
                    sb.push_back(e_push);
                end
                return;
            end
            @(negedge clk);
        end
        d_req_valid = 1'b0;
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_eval(input logic [9:0] a, input logic [9:0] seed, input int hold);
        logic [9:0] exp_d, seed_exp;
        int         runs;
        bit         stable;
        exp_d    = 10'(exp_cnt(int'(a), int'(seed), 10, WD));
        seed_exp = (seed == 10'd0) ? 10'h008 : seed;
        if (hold > 0) d_rsp_ready = 1'b0;
        send(a, seed, 1'b1, exp_d);
        runs   = 0;
        stable = 1'b1;
        for (int i = 0; i < 1200 && d_rsp_valid !== 1'b1; i++) begin
            if (d_dru_rst === 1'b1) runs++;
            if (d_sng_a !== a || d_sng_seed !== seed_exp || d_busy !== 1'b1) stable = 1'b0;
            @(negedge clk);
        end
        check("rsp_arrived", 32'(d_rsp_valid), 32'd1);
        check("run_window", 32'(runs), 32'd1023);
        check("operands_stable", 32'(stable), 32'd1);
        for (int i = 0; i < hold; i++) begin
            d_req_valid = 1'b1;
            d_req_a     = ~a;
            check("hold_valid", 32'(d_rsp_valid), 32'd1);
            check("hold_data", 32'(d_rsp_data), 32'(exp_d));
            check("hold_req_ready", 32'(d_req_ready), 32'd0);
            @(negedge clk);
        end
        if (hold > 0) check("done_no_accept", 32'(d_sng_a), 32'(a));
        d_req_valid = 1'b0;
        d_rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_released", 32'(d_rsp_valid), 32'd0);
        check("back_idle", 32'({d_busy, d_req_ready}), 32'b01);
        last_data = exp_d;
    endtask

    task automatic wait_run_start();
        for (int i = 0; i < 40 && d_dru_rst !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic check_idle_after_abort(input string name);
        check(name, 32'({d_busy, d_dp_rst, d_dru_rst, d_rsp_valid, d_req_ready}), 32'b00001);
        check({name, "_data"}, 32'(d_rsp_data), 32'(last_data));
    endtask

    initial begin
        int e0b, runsb;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({d_req_ready, d_busy, d_rsp_valid, d_dp_rst, d_dru_rst}), 32'b10000);
        check("rst_rsp_data", 32'(d_rsp_data), 32'd0);
        check("rst_sng_a", 32'(d_sng_a), 32'd0);
        check("rst_sng_seed", 32'(d_sng_seed), 32'h008);
        rst = 1'b1;
        @(negedge clk);
        check("req_ready_after_rst", 32'(d_req_ready), 32'd1);

        // N=4, A=12, seed=4: ramp skips 15, 15^4=11 < 12 -> count 11.
        b_req_a = 4'd12; b_req_seed = 4'd4; b_req_valid = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b0;
        e0b   = cyc;
        runsb = 0;
        for (int i = 0; i < 60 && b_rsp_valid !== 1'b1; i++) begin
            if (b_dru_rst === 1'b1) runsb++;
            @(negedge clk);
        end
        check("n4_latency", 32'(cyc - e0b), 32'(LAT_B));
        check("n4_data", 32'(b_rsp_data), 32'd11);
        check("n4_run_window", 32'(runsb), 32'd15);

        run_eval(10'd575, 10'h008, 0);   // default build: 575
        run_eval(10'd300, 10'd0, 0);     // seed 0 -> SEED0; 300
        run_eval(10'd1000, 10'h3F0, 5);  // default build: miss 15 -> 999

        send(10'd500, 10'd5, 1'b0, 10'd0);
        wait_run_start();
        repeat (99) @(negedge clk);
        d_abort = 1'b1;
        @(negedge clk);
        d_abort = 1'b0;
        check_idle_after_abort("abort_run");
        repeat (20) @(negedge clk);

        send(10'd700, 10'd9, 1'b0, 10'd0);
        wait_run_start();
        for (int i = 0; i < 1100 && d_dru_rst === 1'b1; i++) @(negedge clk);
        check("capt_state", 32'({d_busy, d_dp_rst, d_rsp_valid}), 32'b100);
        d_abort = 1'b1;
        @(negedge clk);
        d_abort = 1'b0;
        check_idle_after_abort("abort_capt");
        repeat (10) @(negedge clk);

        send(10'd123, 10'd77, 1'b0, 10'd0);
        wait_run_start();
        repeat (50) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrun_rst_outputs", 32'({d_req_ready, d_busy, d_rsp_valid, d_dp_rst, d_dru_rst}), 32'b10000);
        check("midrun_rst_regs", 32'({d_rsp_data, d_sng_a, d_sng_seed}), 32'({10'd0, 10'd0, 10'h008}));
        last_data = '0;
        @(negedge clk);

        run_eval(10'd0, 10'd3, 0);       // A=0 -> 0
        run_eval(10'd1023, 10'd0, 0);    // A=max, seed 8: miss < 1023 -> 1022

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
